// File: rtl/product_accumulator_pkg.sv
// Shared constants and types for the product accumulator, the MAC stage
// that sits behind the 8x8 combinational multiplier.
package product_accumulator_pkg;

  localparam int MUL_W         = 8;
  localparam int DEFAULT_PROD_W = 2 * MUL_W;
  localparam int DEFAULT_ACC_W  = 24;
  localparam int DEFAULT_CNT_W  = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / sum-out handshake bundle. master = upstream producer plus
// result consumer; slave = the accumulator itself.
interface product_accumulator_if
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = DEFAULT_PROD_W,
  parameter int ACC_W  = DEFAULT_ACC_W,
  parameter int CNT_W  = DEFAULT_CNT_W
);

  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod_data;
  logic              prod_last;

  logic              sum_valid;
  logic              sum_ready;
  logic [ACC_W-1:0]  sum_data;
  logic [CNT_W-1:0]  sum_count;
  logic              sum_ovf;
  logic              sum_trunc;

  modport master (
    output prod_valid, prod_data, prod_last, sum_ready,
    input  prod_ready, sum_valid, sum_data, sum_count, sum_ovf, sum_trunc
  );

  modport slave (
    input  prod_valid, prod_data, prod_last, sum_ready,
    output prod_ready, sum_valid, sum_data, sum_count, sum_ovf, sum_trunc
  );

endinterface

// File: rtl/product_accumulator.sv
// Accumulates a prod_last-delimited packet of unsigned products into one
// wide sum, with sticky overflow and forced termination at max length.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = DEFAULT_PROD_W,
  parameter int ACC_W  = DEFAULT_ACC_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input logic                   clk,
  input logic                   rst,
  product_accumulator_if.slave  bus
);

  // Beat index 2^CNT_W-2 means the incoming beat is the last one that fits.
  localparam logic [CNT_W-1:0] CNT_PENULT = ~CNT_W'(1);

  state_t            state_reg, state_next;
  logic              ready_reg;
  logic [ACC_W-1:0]  acc_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              ovf_reg;

  logic              sum_valid_reg;
  logic [ACC_W-1:0]  sum_data_reg;
  logic [CNT_W-1:0]  sum_count_reg;
  logic              sum_ovf_reg;
  logic              sum_trunc_reg;

  logic              take;
  logic              max_hit;
  logic              final_beat;
  logic              release_sum;
  logic [ACC_W:0]    acc_ext;
  logic [CNT_W-1:0]  cnt_inc;

  always_comb begin
    take        = bus.prod_valid && ready_reg;
    acc_ext     = {1'b0, acc_reg} + (ACC_W+1)'(bus.prod_data);
    cnt_inc     = cnt_reg + CNT_W'(1);
    max_hit     = (cnt_reg == CNT_PENULT);
    final_beat  = take && (bus.prod_last || max_hit);
    release_sum = sum_valid_reg && bus.sum_ready;

    state_next = state_reg;
    case (state_reg)
      ACCUM:   if (final_beat)  state_next = HOLD;
      HOLD:    if (release_sum) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // prod_ready is a register so it never depends combinationally on sum_ready
  // and stays low through reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ACCUM;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_next == ACCUM);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      ovf_reg       <= 1'b0;
      sum_valid_reg <= 1'b0;
      sum_data_reg  <= '0;
      sum_count_reg <= '0;
      sum_ovf_reg   <= 1'b0;
      sum_trunc_reg <= 1'b0;
    end else if (final_beat) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      ovf_reg       <= 1'b0;
      sum_valid_reg <= 1'b1;
      sum_data_reg  <= acc_ext[ACC_W-1:0];
      sum_count_reg <= cnt_inc;
      sum_ovf_reg   <= ovf_reg | acc_ext[ACC_W];
      sum_trunc_reg <= max_hit && !bus.prod_last;
    end else if (take) begin
      acc_reg <= acc_ext[ACC_W-1:0];
      cnt_reg <= cnt_inc;
      ovf_reg <= ovf_reg | acc_ext[ACC_W];
    end else if (release_sum) begin
      // Payload fields deliberately keep their last values.
      sum_valid_reg <= 1'b0;
    end
  end

  assign bus.prod_ready = ready_reg;
  assign bus.sum_valid  = sum_valid_reg;
  assign bus.sum_data   = sum_data_reg;
  assign bus.sum_count  = sum_count_reg;
  assign bus.sum_ovf    = sum_ovf_reg;
  assign bus.sum_trunc  = sum_trunc_reg;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: one 24-bit and one 17-bit accumulator share the same
// stimulus so the overflow case can be seen on both widths.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prod_valid = 1'b0;
  logic [15:0] prod_data = '0;
  logic        prod_last = 1'b0;
  logic        sum_ready = 1'b1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  product_accumulator_if #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) if24 ();
  product_accumulator_if #(.PROD_W(16), .ACC_W(17), .CNT_W(8)) if17 ();

  assign if24.prod_valid = prod_valid;
  assign if24.prod_data  = prod_data;
  assign if24.prod_last  = prod_last;
  assign if24.sum_ready  = sum_ready;
  assign if17.prod_valid = prod_valid;
  assign if17.prod_data  = prod_data;
  assign if17.prod_last  = prod_last;
  assign if17.sum_ready  = sum_ready;

  product_accumulator #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) dut24 (
    .clk (clk),
    .rst (rst),
    .bus (if24.slave)
  );

  product_accumulator #(.PROD_W(16), .ACC_W(17), .CNT_W(8)) dut17 (
    .clk (clk),
    .rst (rst),
    .bus (if17.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; returns #1 after the accepting edge.
  task automatic send_beat(input logic [15:0] d, input logic l);
    int n;
    prod_valid = 1'b1;
    prod_data  = d;
    prod_last  = l;
    n = 0;
    while (if24.prod_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    total++;
    if (n < 50) passed++;
    else $error("FAIL beat_timeout observed=%0d expected<50", n);
    step();
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    $display("beat data=0x%04h last=%0b result_valid=%0b", d, l, if24.sum_valid);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid24"}, 32'(if24.sum_valid), 32'd0);
    chk({tag, "_data24"},  32'(if24.sum_data),  32'd0);
    chk({tag, "_count24"}, 32'(if24.sum_count), 32'd0);
    chk({tag, "_ovf24"},   32'(if24.sum_ovf),   32'd0);
    chk({tag, "_trunc24"}, 32'(if24.sum_trunc), 32'd0);
    chk({tag, "_ready24"}, 32'(if24.prod_ready), 32'd0);
    chk({tag, "_data17"},  32'(if17.sum_data),  32'd0);
    chk({tag, "_ready17"}, 32'(if17.prod_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    step();
    step();
    chk_idle_outputs("reset");
    rst = 1'b0;
    step();
    chk("ready_after_reset", 32'(if24.prod_ready), 32'd1);

    // Basic packet 1+2+3.
    send_beat(16'h0001, 1'b0);
    chk("basic_no_early_valid", 32'(if24.sum_valid), 32'd0);
    send_beat(16'h0002, 1'b0);
    send_beat(16'h0003, 1'b1);
    chk("basic_valid", 32'(if24.sum_valid), 32'd1);
    chk("basic_data",  32'(if24.sum_data),  32'd6);
    chk("basic_count", 32'(if24.sum_count), 32'd3);
    chk("basic_ovf",   32'(if24.sum_ovf),   32'd0);
    chk("basic_trunc", 32'(if24.sum_trunc), 32'd0);
    chk("basic_ready_low", 32'(if24.prod_ready), 32'd0);
    step();
    chk("basic_ready_back", 32'(if24.prod_ready), 32'd1);
    chk("basic_valid_clear", 32'(if24.sum_valid), 32'd0);
    chk("basic_data_kept", 32'(if24.sum_data), 32'd6);

    // Multiplier products 200*200 + 255*255.
    send_beat(16'h9C40, 1'b0);
    send_beat(16'hFE01, 1'b1);
    chk("mult_data",  32'(if24.sum_data),  32'h019A41);
    chk("mult_count", 32'(if24.sum_count), 32'd2);
    chk("mult_data17", 32'(if17.sum_data), 32'h19A41);
    chk("mult_ovf17",  32'(if17.sum_ovf),  32'd0);
    step();

    // Overflow: wraps on 17 bits, fits on 24 bits.
    send_beat(16'hFFFF, 1'b0);
    send_beat(16'hFFFF, 1'b0);
    send_beat(16'h0003, 1'b1);
    chk("ovf_data17", 32'(if17.sum_data), 32'h00001);
    chk("ovf_flag17", 32'(if17.sum_ovf),  32'd1);
    chk("ovf_data24", 32'(if24.sum_data), 32'h020001);
    chk("ovf_flag24", 32'(if24.sum_ovf),  32'd0);
    step();
    send_beat(16'h0005, 1'b1);
    chk("ovf_next_data17", 32'(if17.sum_data),  32'd5);
    chk("ovf_next_flag17", 32'(if17.sum_ovf),   32'd0);
    chk("ovf_next_count",  32'(if17.sum_count), 32'd1);
    step();

    // Backpressure: result held while sum_ready=0, next beat waits.
    sum_ready = 1'b0;
    send_beat(16'h1234, 1'b1);
    prod_valid = 1'b1;
    prod_data  = 16'h0007;
    prod_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready_low", 32'(if24.prod_ready), 32'd0);
      chk("bp_valid",     32'(if24.sum_valid),  32'd1);
      chk("bp_data",      32'(if24.sum_data),   32'h1234);
      step();
    end
    sum_ready = 1'b1;
    step();
    chk("bp_ready_back", 32'(if24.prod_ready), 32'd1);
    chk("bp_valid_clear", 32'(if24.sum_valid), 32'd0);
    step();
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    chk("bp_next_valid", 32'(if24.sum_valid), 32'd1);
    chk("bp_next_data",  32'(if24.sum_data),  32'd7);
    chk("bp_next_count", 32'(if24.sum_count), 32'd1);
    step();

    // Truncation at 255 beats, then a 45-beat packet.
    for (int i = 0; i < 254; i++) send_beat(16'h0001, 1'b0);
    chk("trunc_not_yet", 32'(if24.sum_valid), 32'd0);
    send_beat(16'h0001, 1'b0);
    chk("trunc_valid", 32'(if24.sum_valid), 32'd1);
    chk("trunc_data",  32'(if24.sum_data),  32'd255);
    chk("trunc_count", 32'(if24.sum_count), 32'd255);
    chk("trunc_flag",  32'(if24.sum_trunc), 32'd1);
    chk("trunc_flag17", 32'(if17.sum_trunc), 32'd1);
    step();
    for (int i = 0; i < 44; i++) send_beat(16'h0001, 1'b0);
    send_beat(16'h0001, 1'b1);
    chk("trunc2_data",  32'(if24.sum_data),  32'd45);
    chk("trunc2_count", 32'(if24.sum_count), 32'd45);
    chk("trunc2_flag",  32'(if24.sum_trunc), 32'd0);
    step();

    // Asynchronous reset mid-packet.
    send_beat(16'h00FF, 1'b0);
    send_beat(16'h00FF, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_idle_outputs("rst_async");
    step();
    chk_idle_outputs("rst_held");
    rst = 1'b0;
    step();
    chk("rst_ready_back", 32'(if24.prod_ready), 32'd1);
    send_beat(16'h0004, 1'b1);
    chk("rst_data",  32'(if24.sum_data),  32'd4);
    chk("rst_count", 32'(if24.sum_count), 32'd1);
    chk("rst_data17", 32'(if17.sum_data), 32'd4);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
